lcd_frame_buffer: RTL and testbench

LCD_FRAME_BUFFER -- requirements
Module: lcd_frame_buffer

---
 rtl/lcd_frame_buffer.sv | 102 ++++++++++
 tb/tb_lcd_frame_buffer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_frame_buffer.sv
// lcd_frame_buffer: copies CPU LCD RAM into a double-buffered shadow and serves pixel reads from the front bank
module lcd_frame_buffer #(
   parameter logic [7:0] ENTRIES     = 8'd160,
   parameter logic [7:0] ACK_TIMEOUT = 8'd255
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       vsync,
   input  logic       de,
   input  logic [7:0] video_addr,
   input  logic [1:0] lcd_segment_row,
   output logic       cpu_ram_req,
   output logic [7:0] cpu_ram_addr,
   input  logic       cpu_ram_ack,
   input  logic [3:0] cpu_ram_data,
   output logic       pixel_on,
   output logic       copy_busy,
   output logic       frame_ready,
   output logic       timeout_err
);
   typedef enum logic [1:0] {IDLE, REQ, NEXT} state_t;
   state_t     state;
   logic       front_sel, swap_pending, restart_pending;
   logic [7:0] index, wait_cnt, rd_idx;
   logic [3:0] mem [2][ENTRIES];
   logic       swap, wr, wbank;
   assign swap   = vsync & swap_pending;
   assign wr     = (state == REQ) & cpu_ram_ack;
   assign wbank  = swap ? front_sel : ~front_sel;
   assign rd_idx = (video_addr < ENTRIES) ? video_addr : 8'd0;

   // Shadow banks: only the back bank (the one not displayed after this cycle) is ever written
   always_ff @(posedge clk)
      if (wr) mem[wbank][index] <= cpu_ram_data;

   // Registered pixel lookup from the front bank, masked until a frame has been swapped in
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) pixel_on <= 1'b0;
      else pixel_on <= de & frame_ready & (video_addr < ENTRIES) & mem[front_sel][rd_idx][lcd_segment_row];

   // Copy sequencer with swap, deferred restart and ack timeout handling
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state           <= IDLE;
         cpu_ram_req     <= 1'b0;
         cpu_ram_addr    <= 8'd0;
         copy_busy       <= 1'b0;
         frame_ready     <= 1'b0;
         timeout_err     <= 1'b0;
         front_sel       <= 1'b0;
         swap_pending    <= 1'b0;
         restart_pending <= 1'b0;
         index           <= 8'd0;
         wait_cnt        <= 8'd0;
      end else begin
         if (swap) begin
            front_sel    <= ~front_sel;
            frame_ready  <= 1'b1;
            swap_pending <= 1'b0;
         end
         case (state)
            IDLE:
               if (vsync || restart_pending) begin
                  state           <= REQ;
                  copy_busy       <= 1'b1;
                  cpu_ram_req     <= 1'b1;
                  cpu_ram_addr    <= 8'd0;
                  index           <= 8'd0;
                  wait_cnt        <= 8'd0;
                  restart_pending <= 1'b0;
               end
            REQ: begin
               if (vsync) restart_pending <= 1'b1;
               if (cpu_ram_ack) begin
                  state       <= NEXT;
                  cpu_ram_req <= 1'b0;
               end else if (wait_cnt == ACK_TIMEOUT - 8'd1) begin
                  state        <= IDLE;
                  cpu_ram_req  <= 1'b0;
                  copy_busy    <= 1'b0;
                  timeout_err  <= 1'b1;
                  swap_pending <= 1'b0;
               end else wait_cnt <= wait_cnt + 8'd1;
            end
            NEXT: begin
               if (vsync) restart_pending <= 1'b1;
               if (index == ENTRIES - 8'd1) begin
                  state        <= IDLE;
                  copy_busy    <= 1'b0;
                  swap_pending <= 1'b1;
               end else begin
                  state        <= REQ;
                  cpu_ram_req  <= 1'b1;
                  index        <= index + 8'd1;
                  cpu_ram_addr <= index + 8'd1;
                  wait_cnt     <= 8'd0;
               end
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_lcd_frame_buffer.sv
// tb_lcd_frame_buffer: table vectors, directed corner sequences and random reads against a bank-level model
module tb_lcd_frame_buffer;
   typedef struct {
      logic [7:0] a;
      logic [1:0] r;
      logic       d;
      logic       e;
   } vec_t;

   logic       clk = 1'b0, reset_n = 1'b1, vsync = 1'b0, de = 1'b0, cpu_ram_ack = 1'b0;
   logic [7:0] video_addr = 8'd0;
   logic [1:0] lcd_segment_row = 2'd0;
   logic [3:0] cpu_ram_data = 4'd0;
   logic       cpu_ram_req, pixel_on, copy_busy, frame_ready, timeout_err;
   logic [7:0] cpu_ram_addr;
   int         passed = 0, total = 0;
   logic [3:0] cpu_mem [256];
   logic [3:0] m_front [256];
   logic [3:0] m_pend [256];
   logic       m_ready = 1'b0, m_sel = 1'b0;
   int         ack_delay = 2, req_cnt = 0, overlap = 0;
   bit         no_ack = 1'b0;
   logic [7:0] acked [$];

   lcd_frame_buffer dut (
      .clk(clk), .reset_n(reset_n), .vsync(vsync), .de(de),
      .video_addr(video_addr), .lcd_segment_row(lcd_segment_row),
      .cpu_ram_req(cpu_ram_req), .cpu_ram_addr(cpu_ram_addr),
      .cpu_ram_ack(cpu_ram_ack), .cpu_ram_data(cpu_ram_data),
      .pixel_on(pixel_on), .copy_busy(copy_busy),
      .frame_ready(frame_ready), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // CPU RAM responder: acks each request after ack_delay cycles and logs served addresses
   always @(posedge clk) begin
      #1;
      if (cpu_ram_ack && cpu_ram_req) overlap++;
      if (cpu_ram_req && !cpu_ram_ack && !no_ack) begin
         if (req_cnt == ack_delay) begin
            cpu_ram_ack = 1'b1;
            cpu_ram_data = cpu_mem[cpu_ram_addr];
            acked.push_back(cpu_ram_addr);
            req_cnt = 0;
         end else req_cnt++;
      end else begin
         cpu_ram_ack = 1'b0;
         if (!cpu_ram_req) req_cnt = 0;
      end
   end

   function automatic logic m_pix(input logic [7:0] a, input logic [1:0] r, input logic d);
      return d && m_ready && (a < 8'd160) && m_front[a][r];
   endfunction

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
   endtask

   task automatic pulse_vsync();
      vsync = 1'b1;
      step();
      vsync = 1'b0;
   endtask

   task automatic model_done();
      foreach (m_pend[i]) m_pend[i] = cpu_mem[i];
   endtask

   task automatic model_swap();
      foreach (m_front[i]) m_front[i] = m_pend[i];
      m_ready = 1'b1;
      m_sel = ~m_sel;
   endtask

   task automatic rd(input logic [7:0] a, input logic [1:0] r, input logic d, input logic e, input string nm);
      video_addr = a;
      lcd_segment_row = r;
      de = d;
      step();
      check(nm, pixel_on, e);
   endtask

   task automatic wait_idle(output int cyc);
      cyc = 0;
      while (copy_busy && cyc < 3000) begin
         step();
         cyc++;
      end
   endtask

   task automatic wait_addr(input logic [7:0] a, output int cyc);
      cyc = 0;
      while (!(cpu_ram_req && cpu_ram_addr == a) && cyc < 3000) begin
         step();
         cyc++;
      end
   endtask

   task automatic rand_reads(input int n, input string nm);
      logic [7:0] a;
      logic [1:0] r;
      logic       d;
      for (int k = 0; k < n; k++) begin
         a = 8'($urandom_range(0, 180));
         r = 2'($urandom);
         d = ($urandom % 4) != 0;
         rd(a, r, d, m_pix(a, r, d), nm);
      end
   endtask

   initial begin
      int   cyc, bad;
      vec_t tbl [12];
      tbl[0]  = '{8'h05, 2'd2, 1'b1, 1'b1};
      tbl[1]  = '{8'h05, 2'd1, 1'b1, 1'b0};
      tbl[2]  = '{8'h05, 2'd0, 1'b1, 1'b1};
      tbl[3]  = '{8'h05, 2'd2, 1'b0, 1'b0};
      tbl[4]  = '{8'hA0, 2'd0, 1'b1, 1'b0};
      tbl[5]  = '{8'h9F, 2'd3, 1'b1, 1'b1};
      tbl[6]  = '{8'h10, 2'd0, 1'b1, 1'b0};
      tbl[7]  = '{8'h0F, 2'd0, 1'b1, 1'b1};
      tbl[8]  = '{8'h08, 2'd3, 1'b1, 1'b1};
      tbl[9]  = '{8'hFF, 2'd3, 1'b1, 1'b0};
      tbl[10] = '{8'h9A, 2'd1, 1'b1, 1'b1};
      tbl[11] = '{8'h9A, 2'd0, 1'b1, 1'b0};
      foreach (cpu_mem[i]) begin
         cpu_mem[i] = 4'(i);
         m_front[i] = 4'd0;
         m_pend[i] = 4'd0;
      end
      #1 reset_n = 1'b0;
      repeat (3) step();
      check("rst_req", cpu_ram_req, 0);
      check("rst_addr", cpu_ram_addr, 0);
      check("rst_pixel", pixel_on, 0);
      check("rst_busy", copy_busy, 0);
      check("rst_ready", frame_ready, 0);
      check("rst_timeout", timeout_err, 0);
      check("rst_front_sel", dut.front_sel, 0);
      reset_n = 1'b1;
      step();

      bad = 0;
      for (int a = 0; a < 256; a++) begin
         video_addr = 8'(a);
         lcd_segment_row = 2'(a);
         de = 1'b1;
         step();
         if (pixel_on !== 1'b0) bad++;
      end
      check("blank_before_frame", bad, 0);

      acked.delete();
      overlap = 0;
      pulse_vsync();
      check("busy_after_vsync", copy_busy, 1);
      check("first_req", {cpu_ram_req, cpu_ram_addr}, {1'b1, 8'h00});
      wait_idle(cyc);
      check("copy_len", cyc, 640);
      check("req_count", acked.size(), 160);
      bad = 0;
      foreach (acked[i]) if (acked[i] !== 8'(i)) bad++;
      check("req_addr_order", bad, 0);
      check("req_gap", overlap, 0);
      check("no_swap_yet", frame_ready, 0);
      model_done();
      pulse_vsync();
      model_swap();
      check("front_sel_swap1", dut.front_sel, m_sel);
      check("frame_ready_set", frame_ready, 1);
      foreach (tbl[i]) rd(tbl[i].a, tbl[i].r, tbl[i].d, tbl[i].e, $sformatf("tbl%0d", i));
      video_addr = 8'h05;
      lcd_segment_row = 2'd2;
      de = 1'b1;
      step();
      check("latency_pre", pixel_on, 1);
      video_addr = 8'h10;
      lcd_segment_row = 2'd0;
      #1 check("latency_hold", pixel_on, 1);
      step();
      check("latency_post", pixel_on, 0);
      wait_idle(cyc);
      check("copy2_done", copy_busy, 0);
      model_done();

      foreach (cpu_mem[i]) cpu_mem[i] = 4'($urandom);
      acked.delete();
      pulse_vsync();
      model_swap();
      check("front_sel_swap2", dut.front_sel, m_sel);
      wait_addr(8'd40, cyc);
      check("reach_idx40", cpu_ram_req && cpu_ram_addr == 8'd40, 1);
      pulse_vsync();
      check("no_abort", copy_busy, 1);
      wait_idle(cyc);
      check("copy_ran_to_end", acked.size(), 160);
      check("last_addr", acked[$], 8'd159);
      model_done();
      step();
      check("restart_next_cycle", {copy_busy, cpu_ram_req, cpu_ram_addr}, {1'b1, 1'b1, 8'h00});
      check("swap_deferred", dut.front_sel, m_sel);
      wait_idle(cyc);
      check("restart_done", copy_busy, 0);
      model_done();
      pulse_vsync();
      model_swap();
      check("front_sel_swap3", dut.front_sel, m_sel);
      rand_reads(150, "rand_rd");
      wait_idle(cyc);
      model_done();

      no_ack = 1'b1;
      pulse_vsync();
      model_swap();
      check("front_sel_swap4", dut.front_sel, m_sel);
      cyc = 0;
      while (cpu_ram_req && cyc < 400) begin
         cyc++;
         step();
      end
      check("timeout_req_len", cyc, 255);
      check("timeout_err_set", timeout_err, 1);
      check("timeout_idle", copy_busy, 0);
      check("timeout_front_sel", dut.front_sel, m_sel);
      check("timeout_ready", frame_ready, 1);
      rand_reads(20, "timeout_rd");
      no_ack = 1'b0;
      pulse_vsync();
      check("no_swap_after_timeout", dut.front_sel, m_sel);
      check("timeout_sticky", timeout_err, 1);

      wait_addr(8'd80, cyc);
      check("reach_idx80", cpu_ram_req && cpu_ram_addr == 8'd80, 1);
      reset_n = 1'b0;
      #1;
      check("rst_drops_req", cpu_ram_req, 0);
      check("rst_mid_busy", copy_busy, 0);
      check("rst_mid_ready", frame_ready, 0);
      check("rst_mid_timeout", timeout_err, 0);
      m_ready = 1'b0;
      m_sel = 1'b0;
      step();
      reset_n = 1'b1;
      foreach (cpu_mem[i]) cpu_mem[i] = 4'($urandom);
      check("rst_front_sel_mid", dut.front_sel, 0);
      rd(8'h05, 2'd2, 1'b1, m_pix(8'h05, 2'd2, 1'b1), "masked_after_reset");
      acked.delete();
      pulse_vsync();
      check("restart_after_reset", {cpu_ram_req, cpu_ram_addr}, {1'b1, 8'h00});
      check("front_sel_after_reset", dut.front_sel, 0);
      wait_idle(cyc);
      check("copy_after_reset_len", acked.size(), 160);
      check("no_swap_without_vsync", frame_ready, 0);
      model_done();
      pulse_vsync();
      model_swap();
      check("ready_after_reset_copy", frame_ready, 1);
      check("front_sel_after_copy", dut.front_sel, m_sel);
      rand_reads(40, "post_reset_rd");
      wait_idle(cyc);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
